// File: rtl/exu_disp_queue_pkg.sv
// Shared types for the execute dispatch queue: decode-info layout, group codes
// and the operand-select control view of the info bus.
package exu_disp_queue_pkg;

    localparam int DECINFO_W    = 16;
    localparam int GRP_W        = 3;
    localparam int DISP_NUM_GRP = 6;

    localparam int INFO_OP1PC  = 3;
    localparam int INFO_LUI    = 4;
    localparam int INFO_OP2IMM = 5;
    localparam int INFO_JUMP   = 6;
    localparam int INFO_RS1IMM = 7;

    typedef enum logic [GRP_W-1:0] {
        GRP_ALU    = 3'd0,
        GRP_BJP    = 3'd1,
        GRP_MULDIV = 3'd2,
        GRP_CSR    = 3'd3,
        GRP_MEM    = 3'd4,
        GRP_SYS    = 3'd5
    } grp_e;

    // Field order mirrors info bits [7:0]; codes 6 and 7 map to no unit.
    typedef struct packed {
        logic             rs1imm;
        logic             jump;
        logic             op2imm;
        logic             lui;
        logic             op1pc;
        logic [GRP_W-1:0] grp;
    } opsel_ctl_t;

    function automatic opsel_ctl_t decode_ctl(input logic [7:0] ctl_bits);
        return opsel_ctl_t'(ctl_bits);
    endfunction

endpackage

// File: rtl/exu_disp_queue_if.sv
// Decode-side push bus and execute-side dispatch bus of the dispatch queue.
interface exu_disp_queue_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_GRP = exu_disp_queue_pkg::DISP_NUM_GRP
);
    import exu_disp_queue_pkg::*;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [DECINFO_W-1:0] in_info_i;
    logic [DATA_W-1:0]    in_imm_i;
    logic [DATA_W-1:0]    in_pc_i;
    logic [DATA_W-1:0]    in_rs1_i;
    logic [DATA_W-1:0]    in_rs2_i;

    logic [NUM_GRP-1:0]   disp_valid_o;
    logic [NUM_GRP-1:0]   disp_ready_i;
    logic [DECINFO_W-1:0] disp_info_o;
    logic [DATA_W-1:0]    disp_op1_o;
    logic [DATA_W-1:0]    disp_op2_o;
    logic [DATA_W-1:0]    disp_rs2_o;
    logic [DATA_W-1:0]    disp_pc_o;

    modport master (
        output in_valid_i, in_info_i, in_imm_i, in_pc_i, in_rs1_i, in_rs2_i, disp_ready_i,
        input  in_ready_o, disp_valid_o, disp_info_o, disp_op1_o, disp_op2_o, disp_rs2_o, disp_pc_o
    );

    modport slave (
        input  in_valid_i, in_info_i, in_imm_i, in_pc_i, in_rs1_i, in_rs2_i, disp_ready_i,
        output in_ready_o, disp_valid_o, disp_info_o, disp_op1_o, disp_op2_o, disp_rs2_o, disp_pc_o
    );

endinterface

// File: rtl/exu_disp_opsel.sv
// Combinational operand selection per dispatch group; unmapped groups and SYS
// produce zero operands.
module exu_disp_opsel
    import exu_disp_queue_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  opsel_ctl_t        ctl_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o
);

    always_comb begin
        op1_o = '0;
        op2_o = '0;
        case (ctl_i.grp)
            GRP_ALU: begin
                op1_o = ctl_i.op1pc ? pc_i : (ctl_i.lui ? '0 : rs1_i);
                op2_o = ctl_i.op2imm ? imm_i : rs2_i;
            end
            GRP_BJP: begin
                // Jumps compute the link address PC+4; branches compare rs1/rs2.
                op1_o = ctl_i.jump ? pc_i : rs1_i;
                op2_o = ctl_i.jump ? DATA_W'(4) : rs2_i;
            end
            GRP_MULDIV: begin
                op1_o = rs1_i;
                op2_o = rs2_i;
            end
            GRP_CSR: begin
                op1_o = ctl_i.rs1imm ? imm_i : rs1_i;
            end
            GRP_MEM: begin
                op1_o = rs1_i;
                op2_o = imm_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exu_disp_queue.sv
// In-order dispatch buffer between decode and execute units with per-group issue.
// Define DISP_BYPASS_EN to let an instruction issue straight from the input when the queue is empty.
module exu_disp_queue
    import exu_disp_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int NUM_GRP = DISP_NUM_GRP
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    exu_disp_queue_if.slave        bus,
    output logic                   illegal_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [31:0]            stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    genvar gi;

    logic [DECINFO_W-1:0] info_mem [DEPTH];
    logic [DATA_W-1:0]    op1_mem  [DEPTH];
    logic [DATA_W-1:0]    op2_mem  [DEPTH];
    logic [DATA_W-1:0]    rs2_mem  [DEPTH];
    logic [DATA_W-1:0]    pc_mem   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      stall_q, stall_d;
    logic             illegal_q, illegal_d;

    logic empty, full, push, pop;
    logic head_known, head_legal, head_bad, q_fire;
    logic [DECINFO_W-1:0] head_info;
    logic [GRP_W-1:0]     head_grp;
    logic [NUM_GRP-1:0]   q_valid;

    opsel_ctl_t        in_ctl;
    logic [DATA_W-1:0] wr_op1, wr_op2;

    logic               byp_fire;
    logic [NUM_GRP-1:0] byp_valid;
    logic [DATA_W-1:0]  byp_op1, byp_op2;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    assign in_ctl = decode_ctl(bus.in_info_i[7:0]);

    // Operands are captured at push so later regfile writes cannot alter queued entries.
    exu_disp_opsel #(.DATA_W(DATA_W)) u_opsel_wr (
        .ctl_i (in_ctl),
        .imm_i (bus.in_imm_i),
        .pc_i  (bus.in_pc_i),
        .rs1_i (bus.in_rs1_i),
        .rs2_i (bus.in_rs2_i),
        .op1_o (wr_op1),
        .op2_o (wr_op2)
    );

    assign head_info  = info_mem[head_q];
    assign head_grp   = head_info[GRP_W-1:0];
    assign head_known = int'(head_grp) < NUM_GRP;
    assign head_legal = !empty && head_known;
    assign head_bad   = !empty && !head_known;

    for (gi = 0; gi < NUM_GRP; gi++) begin : g_qsel
        assign q_valid[gi] = head_legal && (head_grp == GRP_W'(gi));
    end

    assign q_fire = |(q_valid & bus.disp_ready_i);

`ifdef DISP_BYPASS_EN
    logic [NUM_GRP-1:0] in_sel;

    for (gi = 0; gi < NUM_GRP; gi++) begin : g_bsel
        assign in_sel[gi] = (in_ctl.grp == GRP_W'(gi));
    end

    // An unmapped group never matches in_sel, so it always goes through storage.
    assign byp_fire  = empty && bus.in_valid_i && !flush_i && |(in_sel & bus.disp_ready_i);
    assign byp_valid = byp_fire ? in_sel : '0;

    exu_disp_opsel #(.DATA_W(DATA_W)) u_opsel_byp (
        .ctl_i (in_ctl),
        .imm_i (bus.in_imm_i),
        .pc_i  (bus.in_pc_i),
        .rs1_i (bus.in_rs1_i),
        .rs2_i (bus.in_rs2_i),
        .op1_o (byp_op1),
        .op2_o (byp_op2)
    );
`else
    assign byp_fire  = 1'b0;
    assign byp_valid = '0;
    assign byp_op1   = '0;
    assign byp_op2   = '0;
`endif

    assign bus.in_ready_o = !full;
    assign push = bus.in_valid_i && !full && !flush_i && !byp_fire;
    assign pop  = !flush_i && (q_fire || head_bad);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign stall_d   = (head_legal && !q_fire && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
    assign illegal_d = head_bad && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            stall_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            stall_q   <= stall_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            info_mem[tail_q] <= bus.in_info_i;
            op1_mem[tail_q]  <= wr_op1;
            op2_mem[tail_q]  <= wr_op2;
            rs2_mem[tail_q]  <= bus.in_rs2_i;
            pc_mem[tail_q]   <= bus.in_pc_i;
        end
    end

    // Every data output is zero whenever nothing is offered to a unit.
    always_comb begin
        bus.disp_valid_o = '0;
        bus.disp_info_o  = '0;
        bus.disp_op1_o   = '0;
        bus.disp_op2_o   = '0;
        bus.disp_rs2_o   = '0;
        bus.disp_pc_o    = '0;
        if (byp_fire) begin
            bus.disp_valid_o = byp_valid;
            bus.disp_info_o  = bus.in_info_i;
            bus.disp_op1_o   = byp_op1;
            bus.disp_op2_o   = byp_op2;
            bus.disp_rs2_o   = bus.in_rs2_i;
            bus.disp_pc_o    = bus.in_pc_i;
        end else if (head_legal) begin
            bus.disp_valid_o = q_valid;
            bus.disp_info_o  = head_info;
            bus.disp_op1_o   = op1_mem[head_q];
            bus.disp_op2_o   = op2_mem[head_q];
            bus.disp_rs2_o   = rs2_mem[head_q];
            bus.disp_pc_o    = pc_mem[head_q];
        end
    end

    assign illegal_o   = illegal_q;
    assign count_o     = count_q;
    assign stall_cnt_o = stall_q;

endmodule
